if_fetch_queue: RTL

//  Parametrised instruction-fetch front end for the N-issue MIPS core: owns the PC,

---
 rtl/if_fetch_queue.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one block fetch at a time to
// the I-side memory port and buffers (pc, inst, adel) entries in a circular queue
// that decode drains 0..FETCH_W entries per cycle. Redirects flush and restart.
//
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   exc                 redirect to EXC_PC (highest priority)
//   redir_valid/_pc     redirect to redir_pc
//   flush               flush queue, refetch from oldest queued pc
//   imem_req/_addr      fetch request and group base address
//   imem_gnt            request accepted this cycle
//   imem_rvalid/_rdata  response; word i of group on bits [32i+31:32i]
//   id_valid/_inst/_pc/_adel  decode lanes, lane 0 = oldest entry
//   deq_cnt             entries consumed by decode this cycle
module if_fetch_queue #(
    parameter int unsigned FETCH_W  = 2,
    parameter int unsigned QDEPTH   = 8,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter logic [31:0] EXC_PC   = 32'hbfc0_0380
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          exc,
    input  logic                          redir_valid,
    input  logic [31:0]                   redir_pc,
    input  logic                          flush,
    output logic                          imem_req,
    output logic [31:0]                   imem_addr,
    input  logic                          imem_gnt,
    input  logic                          imem_rvalid,
    input  logic [32*FETCH_W-1:0]         imem_rdata,
    output logic [FETCH_W-1:0]            id_valid,
    output logic [32*FETCH_W-1:0]         id_inst,
    output logic [32*FETCH_W-1:0]         id_pc,
    output logic [FETCH_W-1:0]            id_adel,
    input  logic [$clog2(FETCH_W+1)-1:0]  deq_cnt
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP, S_HALT} state_t;

    state_t             state_q, state_n;
    logic [31:0]        pc_q, pc_n;
    logic [PTR_W-1:0]   rd_q, rd_n, wr_q, wr_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic [CNT_W-1:0]   free, deq_eff, enq_n;
    logic               misaligned, req_int, redirect, enq_grp, enq_err;
    logic [31:0]        target;

    logic [31:0]        q_pc   [QDEPTH];
    logic [31:0]        q_inst [QDEPTH];
    logic               q_adel [QDEPTH];

    // Request decode and redirect target selection
    always_comb begin
        free       = CNT_W'(QDEPTH) - cnt_q;
        misaligned = (pc_q[1:0] != 2'b00);
        req_int    = (state_q == S_REQ) && !misaligned && (free >= CNT_W'(FETCH_W));
        redirect   = exc | redir_valid | flush;
        if (exc)                target = EXC_PC;
        else if (redir_valid)   target = redir_pc;
        else if (cnt_q != '0)   target = q_pc[rd_q];
        else                    target = pc_q;
    end

    // Gated by reset so no request is visible while reset is held
    assign imem_req  = reset & req_int;
    assign imem_addr = pc_q;

    // Next-state, pointer and count logic
    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        rd_n    = rd_q;
        wr_n    = wr_q;
        cnt_n   = cnt_q;
        enq_grp = 1'b0;
        enq_err = 1'b0;
        enq_n   = '0;
        deq_eff = (CNT_W'(deq_cnt) > cnt_q) ? cnt_q : CNT_W'(deq_cnt);

        if (redirect) begin
            rd_n  = '0;
            wr_n  = '0;
            cnt_n = '0;
            pc_n  = target;
            // A response still owed by memory must be swallowed before refetching
            if ((((state_q == S_WAIT) || (state_q == S_DROP)) && !imem_rvalid) ||
                (req_int && imem_gnt))
                state_n = S_DROP;
            else
                state_n = S_REQ;
        end else begin
            case (state_q)
                S_REQ: begin
                    if (misaligned) begin
                        if (free != '0) begin
                            enq_err = 1'b1;
                            state_n = S_HALT;
                        end
                    end else if (req_int && imem_gnt) begin
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        enq_grp = 1'b1;
                        pc_n    = pc_q + 32'(4 * FETCH_W);
                        state_n = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) state_n = S_REQ;
                end
                S_HALT: ;
                default: state_n = S_REQ;
            endcase

            if (enq_grp)      enq_n = CNT_W'(FETCH_W);
            else if (enq_err) enq_n = CNT_W'(1);
            cnt_n = cnt_q + enq_n - deq_eff;
            rd_n  = rd_q + PTR_W'(deq_eff);
            wr_n  = wr_q + PTR_W'(enq_n);
        end
    end

    // State and pointer registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            rd_q    <= rd_n;
            wr_q    <= wr_n;
            cnt_q   <= cnt_n;
        end
    end

    // Queue storage; contents are qualified by cnt so no reset is needed
    always_ff @(posedge clk) begin
        if (enq_grp) begin
            for (int i = 0; i < int'(FETCH_W); i++) begin
                q_pc[wr_q + PTR_W'(i)]   <= pc_q + 32'(4 * i);
                q_inst[wr_q + PTR_W'(i)] <= imem_rdata[32*i +: 32];
                q_adel[wr_q + PTR_W'(i)] <= 1'b0;
            end
        end else if (enq_err) begin
            q_pc[wr_q]   <= pc_q;
            q_inst[wr_q] <= '0;
            q_adel[wr_q] <= 1'b1;
        end
    end

    // Decode lanes: lane i shows the i-th oldest entry, zeros when invalid
    always_comb begin
        id_valid = '0;
        id_inst  = '0;
        id_pc    = '0;
        id_adel  = '0;
        for (int i = 0; i < int'(FETCH_W); i++) begin
            if (cnt_q > CNT_W'(i)) begin
                id_valid[i]        = 1'b1;
                id_inst[32*i +: 32] = q_inst[rd_q + PTR_W'(i)];
                id_pc[32*i +: 32]   = q_pc[rd_q + PTR_W'(i)];
                id_adel[i]         = q_adel[rd_q + PTR_W'(i)];
            end
        end
    end

endmodule
